// File: rtl/processor_pkg.sv
// Shared fetch-stage definitions: state encoding, NOP word and default widths.
package processor_pkg;

  localparam int unsigned ADDR_W_DEF  = 10;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  localparam logic [INSTR_W_DEF-1:0] NOP = '0;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: PC/control from upstream, instruction memory port, IR to decode.
interface instruction_fetch_if
  import processor_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) ();

  logic [ADDR_W-1:0]  pc;
  logic               stall;
  logic               flush;
  logic               hlt;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               halted;
  logic [CNT_W-1:0]   fetch_cnt;

  // Environment side: PC, control and memory data.
  modport master (
    output pc, stall, flush, hlt, imem_rdata,
    input  imem_addr, imem_rd, instr, instr_pc, instr_valid, halted, fetch_cnt
  );

  // Fetch stage side.
  modport slave (
    input  pc, stall, flush, hlt, imem_rdata,
    output imem_addr, imem_rd, instr, instr_pc, instr_valid, halted, fetch_cnt
  );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one read per cycle to a 1-cycle instruction memory and captures the IR.
// Optional saturating fetch counter enabled by defining IFETCH_CNT_EN.
module instruction_fetch
  import processor_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input logic                clock,
  input logic                reset,
  instruction_fetch_if.slave bus
);

  fetch_state_e       state_q, state_d;
  logic               rd_q, rd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  tag_q, tag_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               capture_c;

  // A returning word lands only if nothing of higher priority kills it.
  assign capture_c = (state_q == FETCH_RUN) && pend_q && !bus.hlt && !bus.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH_BOOT;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
      tag_q    <= '0;
      ir_q     <= INSTR_W'(NOP);
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      pend_q   <= pend_d;
      tag_q    <= tag_d;
      ir_q     <= ir_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    pend_d   = pend_q;
    tag_d    = tag_q;
    ir_d     = ir_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN: begin
        if (bus.hlt) begin
          state_d  = FETCH_HALT;
          rd_d     = 1'b0;
          pend_d   = 1'b0;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else if (bus.flush) begin
          rd_d    = 1'b0;
          pend_d  = 1'b0;
          valid_d = 1'b0;
        end else begin
          // Capture the in-flight word; otherwise a stall holds the IR, else it drains.
          if (capture_c) begin
            ir_d    = bus.imem_rdata;
            ipc_d   = tag_q;
            valid_d = 1'b1;
          end else if (!bus.stall) begin
            valid_d = 1'b0;
          end
          if (bus.stall) begin
            rd_d   = 1'b0;
            pend_d = 1'b0;
          end else begin
            rd_d   = 1'b1;
            addr_d = bus.pc;
            pend_d = 1'b1;
            tag_d  = bus.pc;
          end
        end
      end
      FETCH_HALT: rd_d = 1'b0;
      default:    state_d = FETCH_BOOT;
    endcase
  end

  assign bus.imem_rd     = rd_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = ir_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

`ifdef IFETCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of accepted fetches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (capture_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.fetch_cnt = cnt_q;
`else
  assign bus.fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch against a transaction-level reference model.
module tb_instruction_fetch;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int checks   = 0;
  int failures = 0;

  instruction_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) ifc ();

  instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clock = ~clock;

  // Instruction memory: the registered imem_addr is the memory's address register.
  logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];
  assign ifc.imem_rdata = mem[ifc.imem_addr];

  // Reference model state.
  int                m_state;   // 0 boot, 1 run, 2 halt
  bit                m_rd;
  logic [ADDR_W-1:0] m_addr;
  logic [INSTR_W-1:0] m_instr;
  logic [ADDR_W-1:0] m_ipc;
  bit                m_valid;
  bit                m_halted;
  int                m_cnt;
  logic [ADDR_W-1:0] inflight [$];

  task automatic model_reset();
    m_state = 0; m_rd = 0; m_addr = '0; m_instr = '0; m_ipc = '0;
    m_valid = 0; m_halted = 0; m_cnt = 0;
    inflight.delete();
  endtask

  task automatic model_edge(input logic [ADDR_W-1:0] p, input bit s, input bit f, input bit h);
    logic [ADDR_W-1:0] landed;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (h) begin
        m_state = 2; m_rd = 0; m_valid = 0; m_halted = 1; inflight.delete();
      end else if (f) begin
        m_rd = 0; m_valid = 0; inflight.delete();
      end else begin
        if (inflight.size() > 0) begin
          landed  = inflight.pop_front();
          m_instr = mem[landed];
          m_ipc   = landed;
          m_valid = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end else if (!s) begin
          m_valid = 0;
        end
        if (s) m_rd = 0;
        else begin
          m_rd = 1; m_addr = p; inflight.push_back(p);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_cnt;
`ifdef IFETCH_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk({tag, ".imem_rd"},     64'(ifc.imem_rd),     64'(m_rd));
    chk({tag, ".imem_addr"},   64'(ifc.imem_addr),   64'(m_addr));
    chk({tag, ".instr_valid"}, 64'(ifc.instr_valid), 64'(m_valid));
    chk({tag, ".instr"},       64'(ifc.instr),       64'(m_instr));
    chk({tag, ".instr_pc"},    64'(ifc.instr_pc),    64'(m_ipc));
    chk({tag, ".halted"},      64'(ifc.halted),      64'(m_halted));
    chk({tag, ".fetch_cnt"},   64'(ifc.fetch_cnt),   64'(exp_cnt));
  endtask

  // One clock: drive inputs, step the model on the edge, compare on the falling edge.
  task automatic cycle(input string tag, input logic [ADDR_W-1:0] p,
                       input bit s, input bit f, input bit h);
    ifc.pc = p; ifc.stall = s; ifc.flush = f; ifc.hlt = h;
    @(posedge clock);
    model_edge(p, s, f, h);
    @(negedge clock);
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);

    ifc.pc = '0; ifc.stall = 0; ifc.flush = 0; ifc.hlt = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("reset");
    reset = 1'b1;

    // Sequential fetch of 0..3, then the top address.
    cycle("boot", 10'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("seq", ADDR_W'(i), 0, 0, 0);
    chk("seq.first_instr", 64'(ifc.instr), 64'h0A2);
    cycle("wrap", 10'h3FF, 0, 0, 0);
    cycle("wrap", 10'h004, 0, 0, 0);
    chk("wrap.pc", 64'(ifc.instr_pc), 64'h3FF);

    // Stall with IR holding mem[5].
    cycle("pre5", 10'd5, 0, 0, 0);
    cycle("stall", 10'd6, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 10'd6, 1, 0, 0);
      chk("stall.hold_pc", 64'(ifc.instr_pc), 64'd5);
      chk("stall.no_rd", 64'(ifc.imem_rd), 64'd0);
    end
    cycle("resume", 10'd6, 0, 0, 0);
    chk("resume.addr", 64'(ifc.imem_addr), 64'd6);
    cycle("resume", 10'd7, 0, 0, 0);

    // Flush with pc=7 in flight.
    cycle("flush", 10'h200, 0, 1, 0);
    chk("flush.valid", 64'(ifc.instr_valid), 64'd0);
    cycle("post_flush", 10'h200, 0, 0, 0);
    cycle("post_flush", 10'h201, 0, 0, 0);
    chk("flush.target", 64'(ifc.instr_pc), 64'h200);

    // Randomized traffic.
    for (int i = 0; i < 200; i++)
      cycle("rand", ADDR_W'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 0);

    // Asynchronous reset between edges with a read in flight.
    cycle("pre_rst", 10'd9, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clock);
    reset = 1'b1;
    cycle("rst_boot", 10'h055, 0, 0, 0);
    cycle("rst_issue", 10'h055, 0, 0, 0);
    chk("rst.first_addr", 64'(ifc.imem_addr), 64'h055);

    // Twenty unstalled fetches for counter saturation.
    for (int i = 0; i < 20; i++) cycle("cnt", ADDR_W'(16 + i), 0, 0, 0);
`ifdef IFETCH_CNT_EN
    chk("cnt.saturate", 64'(ifc.fetch_cnt), 64'(CNT_MAX));
`else
    chk("cnt.tied", 64'(ifc.fetch_cnt), 64'd0);
`endif

    // Halt with stall and flush asserted together; only reset leaves it.
    cycle("halt", 10'd40, 1, 1, 1);
    for (int i = 0; i < 20; i++) begin
      cycle("halted", ADDR_W'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
      chk("halt.sticky", 64'(ifc.halted), 64'd1);
    end
    reset = 1'b0;
    #1;
    model_reset();
    check_all("halt_rst");
    @(negedge clock);
    reset = 1'b1;
    cycle("post_halt", 10'd1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
